// File: rtl/mesi_isc_fifo_drain.sv
// Read-side consumer for a mesi_isc_basic_fifo: pops entries, absorbs the one-cycle
// read latency in a 2-entry buffer and presents them on a valid/ready port.
module mesi_isc_fifo_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_rd_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  pop_cnt_o
);

    // Occupancy FSM: each state encodes (buffer count, read in flight).
    // The (2,1) combination cannot be entered because a read is only issued
    // when the post-cycle occupancy stays below 2.
    typedef enum logic [2:0] {
        OCC_EMPTY     = 3'd0,
        OCC_FETCH     = 3'd1,
        OCC_ONE       = 3'd2,
        OCC_ONE_FETCH = 3'd3,
        OCC_FULL      = 3'd4
    } occ_e;

    occ_e                  state_q, state_d;
    logic [1:0]            buf_cnt;
    logic                  inflight;
    logic                  hs;
    logic [1:0]            buf_cnt_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;

    always_comb begin
        buf_cnt  = 2'd0;
        inflight = 1'b0;
        case (state_q)
            OCC_EMPTY:     begin buf_cnt = 2'd0; inflight = 1'b0; end
            OCC_FETCH:     begin buf_cnt = 2'd0; inflight = 1'b1; end
            OCC_ONE:       begin buf_cnt = 2'd1; inflight = 1'b0; end
            OCC_ONE_FETCH: begin buf_cnt = 2'd1; inflight = 1'b1; end
            OCC_FULL:      begin buf_cnt = 2'd2; inflight = 1'b0; end
            default:       begin buf_cnt = 2'd0; inflight = 1'b0; end
        endcase
    end

    assign out_valid_o = (buf_cnt != 2'd0);
    assign busy_o      = (buf_cnt != 2'd0) || inflight;
    assign out_data_o  = out_data_q;
    assign pop_cnt_o   = pop_cnt_q;
    assign hs          = out_valid_o && out_ready_i;

    // A handshake implies buf_cnt >= 1, so this never underflows; the landing
    // read plus remaining entries is exactly next cycle's buffer count.
    assign buf_cnt_d = buf_cnt + {1'b0, inflight} - {1'b0, hs};
    assign fifo_rd_o = !rst && !fifo_empty_i && (buf_cnt_d < 2'd2);

    always_comb begin
        state_d = OCC_EMPTY;
        case ({buf_cnt_d, fifo_rd_o})
            3'b00_0: state_d = OCC_EMPTY;
            3'b00_1: state_d = OCC_FETCH;
            3'b01_0: state_d = OCC_ONE;
            3'b01_1: state_d = OCC_ONE_FETCH;
            3'b10_0: state_d = OCC_FULL;
            default: state_d = OCC_EMPTY;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        if (inflight) begin
            mem_d[tail_q] = fifo_data_i;
        end
        head_d = head_q ^ hs;
        tail_d = tail_q ^ inflight;
        // Look ahead to the entry that will sit at the head after this edge,
        // so the output register is already correct when out_valid_o rises.
        if (buf_cnt_d != 2'd0) begin
            out_data_d = mem_d[head_d];
        end else begin
            out_data_d = out_data_q;
        end
        pop_cnt_d = pop_cnt_q + CNT_WIDTH'(hs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OCC_EMPTY;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            out_data_q <= '0;
            pop_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            mem_q      <= mem_d;
            out_data_q <= out_data_d;
            pop_cnt_q  <= pop_cnt_d;
        end
    end

endmodule

// File: tb/tb_mesi_isc_fifo_drain.sv
// Directed bench for mesi_isc_fifo_drain: a queue models the drained FIFO and
// an expected-data queue checks every delivered entry in order.
module tb_mesi_isc_fifo_drain;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty_i;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_rd_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready_i;
    logic          busy_o;
    logic [CW-1:0] pop_cnt_o;

    always #5 clk = ~clk;

    mesi_isc_fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_rd_o    (fifo_rd_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_ready_i  (out_ready_i),
        .busy_o       (busy_o),
        .pop_cnt_o    (pop_cnt_o)
    );

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            delivered = 0;
    logic          rd_s, valid_s, busy_s;
    logic [DW-1:0] data_s;
    logic [CW-1:0] cnt_s;
    logic          saw_max;
    logic          wrapped;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        fq.push_back(v);
        exp_q.push_back(v);
    endtask

    // One clock cycle: drive inputs, sample settled outputs, score any
    // handshake, then let the FIFO model return popped data after the edge.
    task automatic cycle(input logic rdy);
        out_ready_i  = rdy;
        fifo_empty_i = (fq.size() == 0);
        #1;
        rd_s    = fifo_rd_o;
        valid_s = out_valid_o;
        busy_s  = busy_o;
        data_s  = out_data_o;
        cnt_s   = pop_cnt_o;
        if (fifo_empty_i || rst) check("rd_guard", {31'd0, rd_s}, 32'd0);
        if (valid_s && rdy && !rst) begin
            if (exp_q.size() == 0) check("sb_extra", 32'd1, 32'd0);
            else check("sb_data", data_s, exp_q.pop_front());
            delivered++;
        end
        @(posedge clk);
        #1;
        if (rd_s && fq.size() > 0) fifo_data_i = fq.pop_front();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0);
        cycle(1'b0);
        rst = 1'b0;
        exp_q     = fq;
        delivered = 0;
    endtask

    initial begin
        rst          = 1'b1;
        fifo_empty_i = 1'b1;
        fifo_data_i  = '0;
        out_ready_i  = 1'b0;
        @(posedge clk);
        #1;

        // Three preloaded entries streamed with downstream always ready
        do_reset();
        push(32'hA1); push(32'hA2); push(32'hA3);
        for (int c = 0; c < 6; c++) begin
            cycle(1'b1);
            if (c <= 2) check("t1_rd_on", {31'd0, rd_s}, 32'd1);
            if (c == 3) check("t1_rd_off", {31'd0, rd_s}, 32'd0);
            if (c >= 2 && c <= 4) check("t1_valid", {31'd0, valid_s}, 32'd1);
            if (c == 2) check("t1_first_data", data_s, 32'hA1);
            if (c == 5) begin
                check("t1_valid_end", {31'd0, valid_s}, 32'd0);
                check("t1_busy_end", {31'd0, busy_s}, 32'd0);
                check("t1_cnt", {28'd0, cnt_s}, 32'd3);
                check("t1_hold_data", data_s, 32'hA3);
            end
        end

        // Backpressure: only two reads issued, head held, reads resume with ready
        do_reset();
        push(32'hB1); push(32'hB2); push(32'hB3); push(32'hB4);
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0);
            check("t2_rd", {31'd0, rd_s}, (c < 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                check("t2_valid", {31'd0, valid_s}, 32'd1);
                check("t2_hold", data_s, 32'hB1);
            end
        end
        cycle(1'b1);
        check("t2_resume_rd", {31'd0, rd_s}, 32'd1);
        for (int c = 0; c < 8; c++) cycle(1'b1);
        check("t2_cnt", {28'd0, cnt_s}, 32'd4);
        check("t2_drained", exp_q.size(), 32'd0);

        // Empty FIFO with toggling ready: nothing happens
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cycle(c[0]);
            check("t3_rd", {31'd0, rd_s}, 32'd0);
            check("t3_valid", {31'd0, valid_s}, 32'd0);
        end
        check("t3_cnt", {28'd0, cnt_s}, 32'd0);
        check("t3_busy", {31'd0, busy_s}, 32'd0);

        // Single entry arriving while idle; the write cycle still shows empty
        do_reset();
        cycle(1'b1); cycle(1'b1); cycle(1'b1);
        check("t4_idle_rd", {31'd0, rd_s}, 32'd0);
        push(32'h55);
        cycle(1'b1);
        check("t4_rd", {31'd0, rd_s}, 32'd1);
        check("t4_valid_lat0", {31'd0, valid_s}, 32'd0);
        cycle(1'b1);
        check("t4_valid_lat1", {31'd0, valid_s}, 32'd0);
        check("t4_busy_fetch", {31'd0, busy_s}, 32'd1);
        cycle(1'b1);
        check("t4_valid", {31'd0, valid_s}, 32'd1);
        check("t4_data", data_s, 32'h55);
        cycle(1'b1);
        check("t4_busy_end", {31'd0, busy_s}, 32'd0);
        check("t4_cnt", {28'd0, cnt_s}, 32'd1);

        // Reset with a read in flight: the popped entry is lost, not replayed
        do_reset();
        push(32'hC1); push(32'hC2);
        cycle(1'b0);
        check("t5_rd", {31'd0, rd_s}, 32'd1);
        rst = 1'b1;
        cycle(1'b0);
        rst   = 1'b0;
        exp_q = fq;
        cycle(1'b0);
        check("t5_valid", {31'd0, valid_s}, 32'd0);
        check("t5_busy", {31'd0, busy_s}, 32'd0);
        check("t5_cnt", {28'd0, cnt_s}, 32'd0);
        check("t5_data", data_s, 32'd0);
        for (int c = 0; c < 5; c++) cycle(1'b1);
        check("t5_cnt_end", {28'd0, cnt_s}, 32'd1);
        check("t5_drained", exp_q.size(), 32'd0);

        // 17 entries through a 4-bit counter: wraps 15 -> 0, ends at 1
        do_reset();
        for (int i = 0; i < 17; i++) push(32'h100 + i);
        saw_max = 1'b0;
        wrapped = 1'b0;
        for (int c = 0; c < 22; c++) begin
            cycle(1'b1);
            if (cnt_s == 4'd15) saw_max = 1'b1;
            if (saw_max && cnt_s == 4'd0) wrapped = 1'b1;
        end
        check("t6_wrap", {31'd0, wrapped}, 32'd1);
        check("t6_cnt", {28'd0, cnt_s}, 32'd1);
        check("t6_delivered", delivered, 32'd17);
        check("t6_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
